// File: rtl/ahb_split_slave_ctrl.sv
// Split-capable AHB slave response controller.
// Issues OKAY/wait/SPLIT/ERROR and releases split masters via HSPLITx.
module ahb_split_slave_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [3:0]  HMASTER,
  input  logic        HMASTLOCK,
  input  logic        busy_i,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLITx,
  output logic        xfer_accept_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_SPLIT1 = 3'd2;
  localparam logic [2:0] S_SPLIT2 = 3'd3;
  localparam logic [2:0] S_ERR1   = 3'd4;
  localparam logic [2:0] S_ERR2   = 3'd5;

  localparam logic [7:0] WLAST = 8'(MAX_WAIT - 1);

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [7:0]  wait_cnt;
  logic [3:0]  mst_q;
  logic [15:0] pending;
  logic [15:0] pend_set;
  logic        acc_q;
  logic        valid;
  logic        start;
  logic        rel;
  logic        unused_ok;

  assign unused_ok = HTRANS[0];
  assign valid = HSEL & HTRANS[1] & HREADY;

  // A new transfer is only decided in IDLE or as a locked wait completes.
  assign start = valid & ((state_q == S_IDLE) |
                          ((state_q == S_WAIT) & ~busy_i));

  assign pend_set = (state_q == S_SPLIT1) ? (16'd1 << mst_q) : 16'd0;

  assign rel = ~busy_i & (|pending) &
               (state_q != S_SPLIT1) & (state_q != S_SPLIT2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_IDLE;
      S_WAIT: begin
        if (!busy_i)
          state_d = S_IDLE;
        else if (wait_cnt == WLAST)
          state_d = S_ERR1;
      end
      S_SPLIT1: state_d = S_SPLIT2;
      S_SPLIT2: state_d = S_IDLE;
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (start && busy_i)
      state_d = HMASTLOCK ? S_WAIT : S_SPLIT1;
  end

  always_comb begin
    HREADYOUT     = 1'b1;
    HRESP         = 2'b00;
    xfer_accept_o = 1'b0;
    unique case (state_q)
      S_IDLE:   xfer_accept_o = acc_q;
      S_WAIT: begin
        HREADYOUT     = ~busy_i;
        xfer_accept_o = ~busy_i;
      end
      S_SPLIT1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b11;
      end
      S_SPLIT2: HRESP = 2'b11;
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
      end
      S_ERR2:   HRESP = 2'b01;
      default:  HREADYOUT = 1'b1;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      wait_cnt <= 8'd0;
      mst_q    <= 4'd0;
      pending  <= 16'd0;
      HSPLITx  <= 16'd0;
      acc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= start & ~busy_i;
      if (start && busy_i && HMASTLOCK)
        wait_cnt <= 8'd0;
      else if (state_q == S_WAIT && wait_cnt != 8'hff)
        wait_cnt <= wait_cnt + 8'd1;
      if (start && busy_i && !HMASTLOCK)
        mst_q <= HMASTER;
      // Bits set by SPLIT1 this cycle survive a concurrent release.
      pending <= rel ? pend_set : (pending | pend_set);
      HSPLITx <= rel ? pending : 16'd0;
    end
  end

endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// Directed self-checking bench for ahb_split_slave_ctrl.
// Expected values are hand-derived per cycle.
module tb_ahb_split_slave_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic [3:0]  HMASTER;
  logic        HMASTLOCK;
  logic        busy_i;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [15:0] HSPLITx;
  logic        xfer_accept_o;

  int npass = 0;
  int ntot  = 0;

  always #5 HCLK = ~HCLK;

  assign HREADY = HREADYOUT;

  ahb_split_slave_ctrl #(.MAX_WAIT(15)) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HSEL          (HSEL),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .HMASTER       (HMASTER),
    .HMASTLOCK     (HMASTLOCK),
    .busy_i        (busy_i),
    .HREADYOUT     (HREADYOUT),
    .HRESP         (HRESP),
    .HSPLITx       (HSPLITx),
    .xfer_accept_o (xfer_accept_o)
  );

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv(input logic sel, input logic lock,
                     input logic [3:0] mst, input logic busy);
    HSEL      = sel;
    HTRANS    = sel ? 2'b10 : 2'b00;
    HMASTLOCK = lock;
    HMASTER   = mst;
    busy_i    = busy;
  endtask

  task automatic chk(input string tag, input logic [15:0] o,
                     input logic [15:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  task automatic ck(input string tag, input logic r,
                    input logic [1:0] rs, input logic a,
                    input logic [15:0] sp);
    #1;
    chk({tag, ".rdy"}, {15'd0, HREADYOUT}, {15'd0, r});
    chk({tag, ".resp"}, {14'd0, HRESP}, {14'd0, rs});
    chk({tag, ".acc"}, {15'd0, xfer_accept_o}, {15'd0, a});
    chk({tag, ".split"}, HSPLITx, sp);
  endtask

  initial begin
    HRESETn = 1'b0;
    drv(0, 0, 0, 0);
    tick();
    tick();
    ck("rst", 1, 2'b00, 0, 16'h0);
    chk("rst.pend", dut.pending, 16'h0);
    HRESETn = 1'b1;

    // zero-wait OKAY
    tick();
    drv(1, 0, 3, 0);
    ck("ok.addr", 1, 2'b00, 0, 16'h0);
    tick();
    drv(0, 0, 0, 0);
    ck("ok.data", 1, 2'b00, 1, 16'h0);
    tick();
    ck("ok.after", 1, 2'b00, 0, 16'h0);

    // split masters 5 and 9, then release both together
    drv(1, 0, 5, 1);
    ck("s5.addr", 1, 2'b00, 0, 16'h0);
    tick();
    drv(0, 0, 0, 1);
    ck("s5.s1", 0, 2'b11, 0, 16'h0);
    tick();
    drv(1, 0, 5, 1);
    ck("s5.s2", 1, 2'b11, 0, 16'h0);
    tick();
    drv(1, 0, 9, 1);
    ck("s9.addr", 1, 2'b00, 0, 16'h0);
    tick();
    drv(0, 0, 0, 1);
    ck("s9.s1", 0, 2'b11, 0, 16'h0);
    tick();
    ck("s9.s2", 1, 2'b11, 0, 16'h0);
    tick();
    drv(0, 0, 0, 0);
    ck("rel.cond", 1, 2'b00, 0, 16'h0);
    tick();
    ck("rel.pulse", 1, 2'b00, 0, 16'h0220);
    chk("rel.pend", dut.pending, 16'h0);
    tick();
    ck("rel.end", 1, 2'b00, 0, 16'h0);

    // locked transfer, busy drops after 4 wait cycles
    drv(1, 1, 2, 1);
    ck("lk.addr", 1, 2'b00, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      drv(0, 0, 0, 1);
      ck("lk.wait", 0, 2'b00, 0, 16'h0);
    end
    tick();
    drv(0, 0, 0, 0);
    ck("lk.done", 1, 2'b00, 1, 16'h0);
    tick();
    ck("lk.idle", 1, 2'b00, 0, 16'h0);

    // locked transfer times out
    drv(1, 1, 7, 1);
    ck("to.addr", 1, 2'b00, 0, 16'h0);
    for (int i = 0; i < 15; i++) begin
      tick();
      drv(0, 0, 0, 1);
      ck("to.wait", 0, 2'b00, 0, 16'h0);
    end
    tick();
    ck("to.err1", 0, 2'b01, 0, 16'h0);
    tick();
    drv(1, 1, 7, 1);
    ck("to.err2", 1, 2'b01, 0, 16'h0);
    tick();
    drv(0, 0, 0, 0);
    ck("to.idle", 1, 2'b00, 0, 16'h0);
    tick();
    ck("to.idle2", 1, 2'b00, 0, 16'h0);

    // busy falls during SPLIT1
    drv(1, 0, 4, 1);
    ck("s4.addr", 1, 2'b00, 0, 16'h0);
    tick();
    drv(0, 0, 0, 0);
    ck("s4.s1", 0, 2'b11, 0, 16'h0);
    tick();
    ck("s4.s2", 1, 2'b11, 0, 16'h0);
    tick();
    ck("s4.cond", 1, 2'b00, 0, 16'h0);
    tick();
    ck("s4.pulse", 1, 2'b00, 0, 16'h0010);
    tick();
    ck("s4.end", 1, 2'b00, 0, 16'h0);

    // reset drops pending masters 1 and 6
    drv(1, 0, 1, 1);
    tick();
    drv(0, 0, 0, 1);
    tick();
    tick();
    drv(1, 0, 6, 1);
    tick();
    drv(0, 0, 0, 1);
    ck("s6.s1", 0, 2'b11, 0, 16'h0);
    tick();
    HRESETn = 1'b0;
    ck("rst2", 1, 2'b00, 0, 16'h0);
    chk("rst2.pend", dut.pending, 16'h0);
    tick();
    drv(0, 0, 0, 0);
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ck("rst2.nopulse", 1, 2'b00, 0, 16'h0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/ahb_split_slave_ctrl.md
# ahb_split_slave_ctrl

Split-capable AHB slave response controller: it decides whether a transfer gets OKAY, wait, SPLIT or ERROR, and it tracks which masters it has split. It sits directly upstream of the bus arbiter and drives the arbiter's 16-bit HSPLIT input, which tells the arbiter which split masters may be re-granted. It consumes the arbiter's HMASTER/HMASTLOCK outputs and a single backend busy indication.

## Interface
Parameters:
- MAX_WAIT, 15: maximum wait states inserted for a locked transfer before it is answered with ERROR (legal range 1–255).

Ports:
- HCLK  input  1  bus clock; all state updates on its rising edge.
- HRESETn  input  1  asynchronous, active-low reset.
- HSEL  input  1  slave select, address phase.
- HTRANS  input  2  transfer type; bit 1 set means NONSEQ or SEQ.
- HREADY  input  1  bus-level ready (HREADYin).
- HMASTER  input  4  current address-phase master number, from the arbiter.
- HMASTLOCK  input  1  locked sequence indicator, from the arbiter.
- busy_i  input  1  backend resource busy, sampled with the address phase.
- HREADYOUT  output  1  slave ready.
- HRESP  output  2  response: 00 OKAY, 01 ERROR, 10 RETRY (never driven), 11 SPLIT.
- HSPLITx  output  16  one-cycle release pulse, one bit per master, to the arbiter HSPLIT input.
- xfer_accept_o  output  1  one-cycle pulse in the completing data-phase cycle of each OKAY transfer.

## Operation
- Valid address phase = HSEL & HTRANS[1] & HREADY. IDLE and BUSY transfers get a zero-wait OKAY and cause no state change.
- FSM states: IDLE, WAIT, SPLIT1, SPLIT2, ERR1, ERR2.
- From IDLE, a valid address phase takes one of three paths:
  - busy_i=0: stay in IDLE; the next cycle is a zero-wait OKAY data phase with xfer_accept_o=1.
  - busy_i=1, HMASTLOCK=0: go to SPLIT1 and latch HMASTER into mst_q.
  - busy_i=1, HMASTLOCK=1: go to WAIT and clear wait_cnt. Locked transfers are never split.
- SPLIT1: HREADYOUT=0, HRESP=11. Set pending[mst_q]. Next state is SPLIT2.
- SPLIT2: HREADYOUT=1, HRESP=11. Next state is IDLE. A new address phase sampled in this cycle is ignored, because the master must retry after the split.
- WAIT: HREADYOUT=0, HRESP=00, wait_cnt increments.
  - If busy_i=0: complete with HREADYOUT=1, OKAY and xfer_accept_o=1 in this same cycle. Next state is IDLE, and the address-phase decision above applies to the concurrent transfer.
  - Else if wait_cnt==MAX_WAIT-1: go to ERR1.
- ERR1: HREADYOUT=0, HRESP=01. Next state is ERR2.
- ERR2: HREADYOUT=1, HRESP=01. Next state is IDLE; the concurrent address phase is ignored.
- pending is a 16-bit register. Release condition: busy_i=0 & pending!=0 & state not in {SPLIT1, SPLIT2}. When it holds:
  - the next cycle HSPLITx equals pending;
  - pending clears to 0, except any bit being set by SPLIT1 in that same cycle, which survives.
- A master already pending that is split again keeps its bit set. This is not an error.
- wait_cnt is 8 bits and never wraps, because MAX_WAIT is at most 255.

## Timing
- Reset (asynchronous, immediate): state IDLE, HREADYOUT=1, HRESP=00, HSPLITx=0, xfer_accept_o=0, pending=0, wait_cnt=0, mst_q=0.
- All outputs are registered except HREADYOUT, HRESP and xfer_accept_o, which decode directly from the state and, in WAIT, from busy_i.
- Split response: 2 cycles (SPLIT1, SPLIT2), starting in the cycle after the address phase.
- Release latency: HSPLITx pulses exactly 1 cycle, in the cycle after the first cycle where the release condition holds. The earliest release is the cycle after SPLIT2.
- Locked transfer: 1 to MAX_WAIT data-phase cycles ending in OKAY. Otherwise MAX_WAIT wait cycles followed by ERR1 and ERR2.
- If busy_i falls while a split is being issued (during SPLIT1 or SPLIT2), the split still completes. The master is recorded and released afterwards.
- Reset mid-split or mid-wait drops all pending masters. The arbiter is reset by the same HRESETn.

## Test plan
- busy_i=0; master 3 issues NONSEQ. Required: next cycle HREADYOUT=1, HRESP=00, xfer_accept_o=1; HSPLITx stays 0.
- busy_i=1; master 5, then master 9 (unlocked) each issue a transfer. Required: each gets SPLIT1 (HREADYOUT=0, HRESP=11) then SPLIT2 (HREADYOUT=1, HRESP=11). Then drop busy_i. Required: a single one-cycle pulse HSPLITx=16'h0220, after which pending=0.
- busy_i=1; locked master 2 transfers; busy_i drops after 4 wait cycles. Required: 4 cycles of HREADYOUT=0/OKAY, then HREADYOUT=1/OKAY with xfer_accept_o=1; HSPLITx stays 0.
- MAX_WAIT=15; busy_i held 1; locked master 7 transfers. Required: 15 wait cycles, then ERR1 (0/01), then ERR2 (1/01), then IDLE.
- Split master 4, then drop busy_i during SPLIT1. Required: SPLIT2 completes, then HSPLITx=16'h0010 for 1 cycle, in the cycle after the release condition first holds (after SPLIT2).
- Split masters 1 and 6; assert HRESETn=0 before release. Required: all outputs return to reset values immediately, and no HSPLITx pulse occurs after reset is released.
